// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux among four requesters.
// Grants are held until the owner drops req or HOLD_MAX cycles elapse.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_gnt;
    logic [1:0]        r_sel;
    logic [DATA_W-1:0] r_out;
    logic              r_valid;

    logic [1:0]        w_start;
    logic [1:0]        w_pick;
    logic              w_found;
    logic              w_release;
    logic [DATA_W-1:0] w_mux;

    // While granted, the search starts one past the owner, which is where
    // ptr lands on release; this lets a handoff happen on the same edge.
    always_comb begin
        w_start = (r_state == GRANT) ? r_sel + 2'd1 : r_ptr;
        w_found = 1'b0;
        w_pick  = w_start;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_found && req[w_start + 2'(i)]) begin
                w_found = 1'b1;
                w_pick  = w_start + 2'(i);
            end
        end
    end

    always_comb begin
        w_release = (r_state == GRANT) &&
                    (!req[r_sel] || (r_cnt == CNT_W'(HOLD_MAX - 1)));
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_mux = in_a;
            2'd1:    w_mux = in_b;
            2'd2:    w_mux = in_c;
            default: w_mux = in_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_mux;
            r_valid <= |r_gnt;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_state <= GRANT;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_sel   <= w_pick;
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 2'd1;
                        r_cnt <= '0;
                        if (w_found) begin
                            r_gnt <= 4'b0001 << w_pick;
                            r_sel <= w_pick;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one HOLD_MAX=4 instance and one
// HOLD_MAX=1 instance, with hand-computed expectations.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       in_a, in_b, in_c, in_d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out;
    logic       out_valid;

    logic [3:0] req1;
    logic       in1_a, in1_b;
    logic [3:0] gnt1;
    logic [1:0] sel1;
    logic       out1;
    logic       out_valid1;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.DATA_W(1), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
    );

    mux4_rr_arbiter #(.DATA_W(1), .HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1),
        .in_a(in1_a), .in_b(in1_b), .in_c(1'b0), .in_d(1'b0),
        .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        req1 = 4'b0000;
        in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; in_d = 1'b0;
        in1_a = 1'b0; in1_b = 1'b1;

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", sel, 2'b00);
        chk("rst_out", out, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        tick();
        chk("idle_gnt", gnt, 4'b0000);
        chk("idle_valid", out_valid, 1'b0);

        // 2: lone requester c, re-granted after each hold period
        in_c = 1'b1;
        req  = 4'b0100;
        tick();
        chk("c_gnt", gnt, 4'b0100);
        chk("c_sel", sel, 2'b10);
        chk("c_valid0", out_valid, 1'b0);
        for (int t = 2; t <= 7; t++) begin
            tick();
            chk("c_hold_gnt", gnt, 4'b0100);
            chk("c_hold_out", out, 1'b1);
            chk("c_hold_valid", out_valid, 1'b1);
        end

        // 3: all four requesting, 4-cycle slots a,b,c,d,a
        req = 4'b0000;
        in_a = 1'b0; in_b = 1'b1; in_c = 1'b0; in_d = 1'b1;
        do_reset();
        req = 4'b1111;
        for (int t = 1; t <= 17; t++) begin
            int owner;
            int prev;
            tick();
            owner = ((t - 1) / 4) % 4;
            prev  = ((t - 2) / 4) % 4;
            chk("rr_gnt", gnt, 4'b0001 << owner);
            chk("rr_sel", sel, owner);
            if (t >= 2) begin
                chk("rr_valid", out_valid, 1'b1);
                chk("rr_out", out, prev % 2);
            end
        end

        // 4: b drops after two cycles with a and d pending -> d, then a
        req = 4'b0000;
        in_a = 1'b1; in_b = 1'b1; in_c = 1'b0; in_d = 1'b0;
        do_reset();
        req = 4'b0010;
        tick();
        chk("b_gnt", gnt, 4'b0010);
        tick();
        chk("b_gnt2", gnt, 4'b0010);
        req = 4'b1001;
        tick();
        chk("drop_gnt_d", gnt, 4'b1000);
        chk("drop_sel_d", sel, 2'b11);
        chk("drop_out_b", out, 1'b1);
        chk("drop_valid", out_valid, 1'b1);
        tick();
        chk("d_out", out, 1'b0);
        tick();
        tick();
        chk("d_hold4", gnt, 4'b1000);
        tick();
        chk("then_a_gnt", gnt, 4'b0001);
        chk("then_a_sel", sel, 2'b00);

        // 5: reset during d's grant clears ptr (ptr was 3 before reset)
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        tick();
        chk("c_pre", gnt, 4'b0100);
        req = 4'b1000;
        tick();
        chk("d_pre", gnt, 4'b1000);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_sel", sel, 2'b00);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_out", out, 1'b0);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        chk("post_rst_b", gnt, 4'b0010);
        chk("post_rst_sel", sel, 2'b01);

        // 6: HOLD_MAX=1, a and b alternate every cycle
        req = 4'b0000;
        do_reset();
        req1 = 4'b0011;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("h1_sel", sel1, (t % 2 == 1) ? 2'b00 : 2'b01);
            chk("h1_gnt", gnt1, (t % 2 == 1) ? 4'b0001 : 4'b0010);
            if (t >= 2) begin
                chk("h1_out", out1, (t % 2 == 1) ? 1'b1 : 1'b0);
                chk("h1_valid", out_valid1, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
